seg7_scan_capture: RTL and testbench

- Reverse direction of the team's hex-to-7-segment decoder.
- Watches a multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit enables) and recovers the 4-bit value shown on each digit.
- A capture is accepted only after the bus has been stable for a set number of cycles; the block then raises a ready/valid event.
- Sits beside the display driver as a self-check and readback path for the processor's display output.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_pattern_lookup.sv | 36 +++
 rtl/seg7_scan_capture.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment capture path.
// Segment codes are active-low, written a..g from left to right.
package seg7_pkg;

  localparam logic [0:6] SEG_0    = 7'b0000001;
  localparam logic [0:6] SEG_1    = 7'b1001111;
  localparam logic [0:6] SEG_2    = 7'b0010010;
  localparam logic [0:6] SEG_3    = 7'b0000110;
  localparam logic [0:6] SEG_4    = 7'b1001100;
  localparam logic [0:6] SEG_5    = 7'b0100100;
  localparam logic [0:6] SEG_6    = 7'b0100000;
  localparam logic [0:6] SEG_7    = 7'b0001111;
  localparam logic [0:6] SEG_8    = 7'b0000000;
  localparam logic [0:6] SEG_9    = 7'b0000100;
  localparam logic [0:6] SEG_A    = 7'b0001000;
  localparam logic [0:6] SEG_B    = 7'b1100000;
  localparam logic [0:6] SEG_C    = 7'b0110001;
  localparam logic [0:6] SEG_D    = 7'b1000010;
  localparam logic [0:6] SEG_E    = 7'b0110000;
  localparam logic [0:6] SEG_F    = 7'b0111000;
  localparam logic [0:6] SEG_DASH = 7'b1111110;

  typedef enum logic [1:0] {
    HEX     = 2'b00,
    DASH    = 2'b01,
    INVALID = 2'b10
  } evt_kind_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational inverse of the hex-to-7-segment decode table.
// Nibble is 0 whenever the pattern is not a legal hex code.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output evt_kind_t  kind,
  output logic [3:0] nibble
);

  always_comb begin
    kind   = HEX;
    nibble = 4'h0;
    case (seg)
      SEG_0:    nibble = 4'h0;
      SEG_1:    nibble = 4'h1;
      SEG_2:    nibble = 4'h2;
      SEG_3:    nibble = 4'h3;
      SEG_4:    nibble = 4'h4;
      SEG_5:    nibble = 4'h5;
      SEG_6:    nibble = 4'h6;
      SEG_7:    nibble = 4'h7;
      SEG_8:    nibble = 4'h8;
      SEG_9:    nibble = 4'h9;
      SEG_A:    nibble = 4'hA;
      SEG_B:    nibble = 4'hB;
      SEG_C:    nibble = 4'hC;
      SEG_D:    nibble = 4'hD;
      SEG_E:    nibble = 4'hE;
      SEG_F:    nibble = 4'hF;
      SEG_DASH: kind   = DASH;
      default:  kind   = INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers per-digit values from a multiplexed active-low 7-segment bus and
// emits a single-entry capture event once a digit has been stable long enough.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                          Clk,
  input  logic                          ResetN,
  input  logic [0:6]                    Seg,
  input  logic [NUM_DIGITS-1:0]         DigitSel,
  output logic [4*NUM_DIGITS-1:0]       Nibbles,
  output logic [NUM_DIGITS-1:0]         DigitValid,
  output logic                          EvtValid,
  input  logic                          EvtReady,
  output logic [$clog2(NUM_DIGITS)-1:0] EvtDigit,
  output logic [3:0]                    EvtNibble,
  output logic [1:0]                    EvtKind,
  output logic                          Overrun
);

  localparam int unsigned DigW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [NUM_DIGITS-1:0] SelOne = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [0:6]              seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   sel_q, sel_prev_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    armed_q, armed_d;
  logic [4*NUM_DIGITS-1:0] nibbles_q, nibbles_d;
  logic [NUM_DIGITS-1:0]   dvalid_q, dvalid_d;
  logic                    evt_valid_q, evt_valid_d;
  logic [DigW-1:0]         evt_digit_q, evt_digit_d;
  logic [3:0]              evt_nibble_q, evt_nibble_d;
  evt_kind_t               evt_kind_q, evt_kind_d;
  logic                    overrun_q, overrun_d;

  logic            changed, one_hot, capture;
  logic [DigW-1:0] sel_idx;
  evt_kind_t       lk_kind;
  logic [3:0]      lk_nibble;

  seg7_pattern_lookup u_lookup (
    .seg    (seg_q),
    .kind   (lk_kind),
    .nibble (lk_nibble)
  );

  assign changed = (seg_q != seg_prev_q) || (sel_q != sel_prev_q);
  assign one_hot = (sel_q != '0) && ((sel_q & (sel_q - SelOne)) == '0);

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) sel_idx = DigW'(i);
    end
  end

  // Counter sits at 0 while blanked; a change always restarts at 1 and re-arms.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (changed) armed_d = 1'b1;
    if (!one_hot) begin
      cnt_d = '0;
    end else if (changed) begin
      cnt_d = CntW'(1);
    end else if (cnt_q < CntW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    capture = one_hot && armed_q && (cnt_d == CntW'(STABLE_CYCLES));
    if (capture) armed_d = 1'b0;
  end

  always_comb begin
    nibbles_d    = nibbles_q;
    dvalid_d     = dvalid_q;
    evt_valid_d  = evt_valid_q;
    evt_digit_d  = evt_digit_q;
    evt_nibble_d = evt_nibble_q;
    evt_kind_d   = evt_kind_q;
    overrun_d    = overrun_q;

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (capture && sel_q[i]) begin
        dvalid_d[i] = (lk_kind == HEX);
        if (lk_kind == HEX) nibbles_d[4*i +: 4] = lk_nibble;
      end
    end

    // Single-entry event slot: a pop and a push in the same cycle lose nothing.
    if (capture) begin
      if (!evt_valid_q || EvtReady) begin
        evt_valid_d  = 1'b1;
        evt_digit_d  = sel_idx;
        evt_nibble_d = (lk_kind == HEX) ? lk_nibble : 4'h0;
        evt_kind_d   = lk_kind;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (evt_valid_q && EvtReady) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      seg_q        <= '0;
      sel_q        <= '0;
      seg_prev_q   <= '0;
      sel_prev_q   <= '0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      nibbles_q    <= '0;
      dvalid_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_digit_q  <= '0;
      evt_nibble_q <= '0;
      evt_kind_q   <= HEX;
      overrun_q    <= 1'b0;
    end else begin
      seg_q        <= Seg;
      sel_q        <= DigitSel;
      seg_prev_q   <= seg_q;
      sel_prev_q   <= sel_q;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      nibbles_q    <= nibbles_d;
      dvalid_q     <= dvalid_d;
      evt_valid_q  <= evt_valid_d;
      evt_digit_q  <= evt_digit_d;
      evt_nibble_q <= evt_nibble_d;
      evt_kind_q   <= evt_kind_d;
      overrun_q    <= overrun_d;
    end
  end

  assign Nibbles    = nibbles_q;
  assign DigitValid = dvalid_q;
  assign EvtValid   = evt_valid_q;
  assign EvtDigit   = evt_digit_q;
  assign EvtNibble  = evt_nibble_q;
  assign EvtKind    = evt_kind_q;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed, table-driven bench for seg7_scan_capture with hand-computed expectations.
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic [0:6]  Seg;
  logic [3:0]  DigitSel;
  logic [15:0] Nibbles;
  logic [3:0]  DigitValid;
  logic        EvtValid;
  logic        EvtReady;
  logic [1:0]  EvtDigit;
  logic [3:0]  EvtNibble;
  logic [1:0]  EvtKind;
  logic        Overrun;

  int checks = 0;
  int errors = 0;

  seg7_scan_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (8)
  ) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .Seg        (Seg),
    .DigitSel   (DigitSel),
    .Nibbles    (Nibbles),
    .DigitValid (DigitValid),
    .EvtValid   (EvtValid),
    .EvtReady   (EvtReady),
    .EvtDigit   (EvtDigit),
    .EvtNibble  (EvtNibble),
    .EvtKind    (EvtKind),
    .Overrun    (Overrun)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a pattern for n cycles (EvtReady as currently set) and summarise events seen.
  task automatic hold(input logic [0:6] s, input logic [3:0] d, input int n,
                      output int evts, output int first_at, output logic [1:0] dig,
                      output logic [3:0] nib, output logic [1:0] kind);
    Seg = s;
    DigitSel = d;
    evts = 0;
    first_at = 0;
    dig = '0;
    nib = '0;
    kind = '0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (EvtValid) begin
        evts++;
        if (first_at == 0) begin
          first_at = i;
          dig = EvtDigit;
          nib = EvtNibble;
          kind = EvtKind;
        end
      end
    end
  endtask

  typedef struct {
    logic [0:6] seg;
    logic [1:0] kind;
    logic [3:0] nib;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int evts, first_at, acc;
    logic [1:0]  dig, kind;
    logic [3:0]  nib;
    logic [15:0] exp_nibbles;
    logic [3:0]  exp_dv;
    int d;

    tbl[0]  = '{SEG_0, 2'b00, 4'h0};  tbl[1]  = '{SEG_1, 2'b00, 4'h1};
    tbl[2]  = '{SEG_2, 2'b00, 4'h2};  tbl[3]  = '{SEG_3, 2'b00, 4'h3};
    tbl[4]  = '{SEG_4, 2'b00, 4'h4};  tbl[5]  = '{SEG_5, 2'b00, 4'h5};
    tbl[6]  = '{SEG_6, 2'b00, 4'h6};  tbl[7]  = '{SEG_7, 2'b00, 4'h7};
    tbl[8]  = '{SEG_8, 2'b00, 4'h8};  tbl[9]  = '{SEG_9, 2'b00, 4'h9};
    tbl[10] = '{SEG_A, 2'b00, 4'hA};  tbl[11] = '{SEG_B, 2'b00, 4'hB};
    tbl[12] = '{SEG_C, 2'b00, 4'hC};  tbl[13] = '{SEG_D, 2'b00, 4'hD};
    tbl[14] = '{SEG_E, 2'b00, 4'hE};  tbl[15] = '{SEG_F, 2'b00, 4'hF};
    tbl[16] = '{7'b1111110, 2'b01, 4'h0};
    tbl[17] = '{7'b1111111, 2'b10, 4'h0};

    // Reset state
    ResetN = 1'b0;
    Seg = 7'b1111111;
    DigitSel = 4'b0000;
    EvtReady = 1'b1;
    repeat (3) step();
    chk("reset_nibbles", 32'(Nibbles), 32'h0);
    chk("reset_digitvalid", 32'(DigitValid), 32'h0);
    chk("reset_evtvalid", 32'(EvtValid), 32'h0);
    chk("reset_evtfields", {22'h0, EvtDigit, EvtNibble, EvtKind}, 32'h0);
    chk("reset_overrun", 32'(Overrun), 32'h0);
    ResetN = 1'b1;

    // Basic capture: first event 9 edges after the pattern is applied
    hold(SEG_2, 4'b0001, 12, evts, first_at, dig, nib, kind);
    chk("basic_count", 32'(evts), 32'd1);
    chk("basic_latency", 32'(first_at), 32'd9);
    chk("basic_fields", {24'h0, dig, nib, kind}, {24'h0, 2'd0, 4'h2, 2'b00});
    chk("basic_nibbles", 32'(Nibbles[3:0]), 32'h2);
    chk("basic_digitvalid", 32'(DigitValid), 32'b0001);

    // Stability filter: toggling every 3 cycles never settles
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      hold((k % 2 == 0) ? SEG_5 : SEG_6, 4'b0010, 3, evts, first_at, dig, nib, kind);
      acc += evts;
    end
    chk("filter_no_event", 32'(acc), 32'd0);
    chk("filter_dv1", 32'(DigitValid[1]), 32'd0);
    hold(SEG_6, 4'b0010, 12, evts, first_at, dig, nib, kind);
    chk("filter_count", 32'(evts), 32'd1);
    chk("filter_latency", 32'(first_at), 32'd9);
    chk("filter_fields", {24'h0, dig, nib, kind}, {24'h0, 2'd1, 4'h6, 2'b00});

    // Full scan from the table
    exp_nibbles = 16'h0062;
    exp_dv = 4'b0011;
    for (int i = 0; i < 18; i++) begin
      d = i % 4;
      hold(tbl[i].seg, 4'b0001 << d, 10, evts, first_at, dig, nib, kind);
      if (tbl[i].kind == 2'b00) begin
        exp_nibbles[4*d +: 4] = tbl[i].nib;
        exp_dv[d] = 1'b1;
      end else begin
        exp_dv[d] = 1'b0;
      end
      chk($sformatf("scan%0d_count", i), 32'(evts), 32'd1);
      chk($sformatf("scan%0d_fields", i), {24'h0, dig, nib, kind},
          {24'h0, 2'(d), tbl[i].nib, tbl[i].kind});
      chk($sformatf("scan%0d_nibbles", i), 32'(Nibbles), 32'(exp_nibbles));
      chk($sformatf("scan%0d_digitvalid", i), 32'(DigitValid), 32'(exp_dv));
    end

    // Backpressure: second capture is dropped, third is pop+push
    EvtReady = 1'b0;
    hold(SEG_A, 4'b0001, 10, evts, first_at, dig, nib, kind);
    hold(SEG_F, 4'b0100, 10, evts, first_at, dig, nib, kind);
    chk("bp_evtvalid", 32'(EvtValid), 32'd1);
    chk("bp_fields", {24'h0, EvtDigit, EvtNibble, EvtKind}, {24'h0, 2'd0, 4'hA, 2'b00});
    chk("bp_overrun", 32'(Overrun), 32'd1);
    chk("bp_nibbles_d2", 32'(Nibbles[11:8]), 32'hF);
    hold(SEG_3, 4'b1000, 8, evts, first_at, dig, nib, kind);
    chk("bp_stable_fields", {24'h0, EvtDigit, EvtNibble, EvtKind}, {24'h0, 2'd0, 4'hA, 2'b00});
    EvtReady = 1'b1;
    step();
    chk("bp_pushpop_valid", 32'(EvtValid), 32'd1);
    chk("bp_pushpop_fields", {24'h0, EvtDigit, EvtNibble, EvtKind},
        {24'h0, 2'd3, 4'h3, 2'b00});
    step();
    chk("bp_drain", 32'(EvtValid), 32'd0);
    chk("bp_overrun_sticky", 32'(Overrun), 32'd1);

    // Reset in the middle of a stability count
    hold(SEG_7, 4'b0100, 6, evts, first_at, dig, nib, kind);
    chk("rst_pre_no_event", 32'(evts), 32'd0);
    ResetN = 1'b0;
    step();
    chk("rst_mid_nibbles", 32'(Nibbles), 32'h0);
    chk("rst_mid_flags", {28'h0, EvtValid, Overrun, DigitValid[2], EvtNibble[0]}, 32'h0);
    ResetN = 1'b1;
    hold(SEG_7, 4'b0100, 12, evts, first_at, dig, nib, kind);
    chk("rst_release_count", 32'(evts), 32'd1);
    chk("rst_release_latency", 32'(first_at), 32'd9);
    chk("rst_release_fields", {24'h0, dig, nib, kind}, {24'h0, 2'd2, 4'h7, 2'b00});

    // Blanking and re-selection of an identical pattern
    hold(SEG_8, 4'b0000, 20, evts, first_at, dig, nib, kind);
    chk("blank_zero", 32'(evts), 32'd0);
    hold(SEG_8, 4'b0110, 20, evts, first_at, dig, nib, kind);
    chk("blank_multi", 32'(evts), 32'd0);
    hold(SEG_8, 4'b0010, 12, evts, first_at, dig, nib, kind);
    chk("reselect_count", 32'(evts), 32'd1);
    chk("reselect_fields", {24'h0, dig, nib, kind}, {24'h0, 2'd1, 4'h8, 2'b00});
    hold(SEG_8, 4'b0000, 3, evts, first_at, dig, nib, kind);
    hold(SEG_8, 4'b0010, 12, evts, first_at, dig, nib, kind);
    chk("reselect_same_count", 32'(evts), 32'd1);
    chk("reselect_same_latency", 32'(first_at), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
